alarm_timekeeper: RTL and testbench

Time-of-day counter and alarm comparator for the alarm clock, fed by the 1 Hz divided clock from the clock divider stage. It detects each rising edge of the divided clock and advances a binary hours/minutes/seconds count. It accepts user loads of time and alarm settings, and raises a latched alarm output when the running time reaches the programmed alarm time. Its outputs drive the display/BCD conversion stage and the buzzer logic.

---
 rtl/alarm_timekeeper_if.sv | 26 ++
 rtl/alarm_timekeeper.sv | 124 ++++++++++++
 tb/tb_alarm_timekeeper.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_timekeeper_if.sv
// rtl/alarm_timekeeper_if.sv - user-side signal bundle for the alarm timekeeper
interface alarm_timekeeper_if;
  logic       tick_in;
  logic       set_time;
  logic       set_alarm;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic       alarm_en;
  logic       alarm_ack;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       sec_pulse;
  logic       alarm_ring;
  logic       set_err;

  modport master (
    output tick_in, set_time, set_alarm, set_hh, set_mm, alarm_en, alarm_ack,
    input  hh, mm, ss, sec_pulse, alarm_ring, set_err
  );

  modport slave (
    input  tick_in, set_time, set_alarm, set_hh, set_mm, alarm_en, alarm_ack,
    output hh, mm, ss, sec_pulse, alarm_ring, set_err
  );
endinterface

// File: rtl/alarm_timekeeper.sv
// rtl/alarm_timekeeper.sv - hh:mm:ss counter with load and latched alarm comparator
module alarm_timekeeper #(
  parameter int ALARM_LEN = 60
) (
  input  logic                clk,
  input  logic                rst,
  alarm_timekeeper_if.slave   bus
);

  localparam logic [5:0] RING_LAST = 6'(ALARM_LEN - 1);

  typedef enum logic {S_IDLE, S_RING} ring_state_t;

  logic       tick_q;
  logic [4:0] hh_r, al_hh;
  logic [5:0] mm_r, ss_r, al_mm;
  logic       sec_pulse_r, set_err_r;
  logic [5:0] ring_cnt, ring_cnt_nx;
  ring_state_t state, state_nx;

  logic       tick_edge, ld_ok, time_ld, alarm_ld, advance, match;
  logic [4:0] nx_hh;
  logic [5:0] nx_mm, nx_ss;

  assign tick_edge = bus.tick_in & ~tick_q;
  assign ld_ok     = (bus.set_hh <= 5'd23) && (bus.set_mm <= 6'd59);
  assign time_ld   = bus.set_time & ld_ok;
  assign alarm_ld  = bus.set_alarm & ld_ok;
  // A successful time load swallows a coincident tick edge; a rejected one does not.
  assign advance   = tick_edge & ~time_ld;
  assign match     = bus.alarm_en & advance & (nx_hh == al_hh) &
                     (nx_mm == al_mm) & (nx_ss == 6'd0);

  // Successor time with seconds -> minutes -> hours carry and midnight wrap.
  always_comb begin
    nx_ss = ss_r + 6'd1;
    nx_mm = mm_r;
    nx_hh = hh_r;
    if (ss_r == 6'd59) begin
      nx_ss = 6'd0;
      if (mm_r == 6'd59) begin
        nx_mm = 6'd0;
        nx_hh = (hh_r == 5'd23) ? 5'd0 : hh_r + 5'd1;
      end else begin
        nx_mm = mm_r + 6'd1;
      end
    end
  end

  // Time-of-day, alarm setting, edge-detect and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q      <= 1'b0;
      hh_r        <= 5'd0;
      mm_r        <= 6'd0;
      ss_r        <= 6'd0;
      al_hh       <= 5'd0;
      al_mm       <= 6'd0;
      sec_pulse_r <= 1'b0;
      set_err_r   <= 1'b0;
    end else begin
      tick_q      <= bus.tick_in;
      sec_pulse_r <= advance;
      set_err_r   <= (bus.set_time | bus.set_alarm) & ~ld_ok;
      if (time_ld) begin
        hh_r <= bus.set_hh;
        mm_r <= bus.set_mm;
        ss_r <= 6'd0;
      end else if (advance) begin
        hh_r <= nx_hh;
        mm_r <= nx_mm;
        ss_r <= nx_ss;
      end
      if (alarm_ld) begin
        al_hh <= bus.set_hh;
        al_mm <= bus.set_mm;
      end
    end
  end

  // Ring state and advance counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ring_cnt <= 6'd0;
    end else begin
      state    <= state_nx;
      ring_cnt <= ring_cnt_nx;
    end
  end

  // Ring control: disarm beats everything, then a fresh match, then ack/timeout.
  always_comb begin
    state_nx    = state;
    ring_cnt_nx = ring_cnt;
    if (!bus.alarm_en) begin
      state_nx    = S_IDLE;
      ring_cnt_nx = 6'd0;
    end else if (match) begin
      state_nx    = S_RING;
      ring_cnt_nx = 6'd0;
    end else if (state == S_RING) begin
      if (bus.alarm_ack) begin
        state_nx    = S_IDLE;
        ring_cnt_nx = 6'd0;
      end else if (advance) begin
        if (ring_cnt == RING_LAST) begin
          state_nx    = S_IDLE;
          ring_cnt_nx = 6'd0;
        end else begin
          ring_cnt_nx = ring_cnt + 6'd1;
        end
      end
    end
  end

  assign bus.hh         = hh_r;
  assign bus.mm         = mm_r;
  assign bus.ss         = ss_r;
  assign bus.sec_pulse  = sec_pulse_r;
  assign bus.set_err    = set_err_r;
  assign bus.alarm_ring = (state == S_RING);

endmodule

// File: tb/tb_alarm_timekeeper.sv
// tb/tb_alarm_timekeeper.sv - scoreboard bench for alarm_timekeeper
module tb_alarm_timekeeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_req = 1'b0;
  logic done_req = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    string      name;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       ring;
    logic       sp;
    logic       se;
  } exp_t;

  exp_t exp_q[$];

  alarm_timekeeper_if bus ();

  alarm_timekeeper #(.ALARM_LEN(60)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within 400000 ns");
    $fatal(1, "watchdog expired");
  end

  // Monitor: one scoreboard entry per cycle in which the DUT pulses or a snapshot is requested.
  always @(negedge clk) begin
    if (done_req) begin
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL leftover: %0d expected entries never observed, required 0", exp_q.size());
    end else if (bus.sec_pulse || bus.set_err || sample_req) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected: sp=%0b se=%0b at %0d:%0d:%0d, required no activity",
                 bus.sec_pulse, bus.set_err, bus.hh, bus.mm, bus.ss);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.hh === e.hh && bus.mm === e.mm && bus.ss === e.ss &&
            bus.alarm_ring === e.ring && bus.sec_pulse === e.sp && bus.set_err === e.se)
          n_pass++;
        else
          $display("FAIL %s: got %0d:%0d:%0d ring=%0b sp=%0b se=%0b, required %0d:%0d:%0d ring=%0b sp=%0b se=%0b",
                   e.name, bus.hh, bus.mm, bus.ss, bus.alarm_ring, bus.sec_pulse, bus.set_err,
                   e.hh, e.mm, e.ss, e.ring, e.sp, e.se);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string n, int h, int m, int s, bit r, bit sp, bit se);
    exp_t e;
    e.name = n; e.hh = 5'(h); e.mm = 6'(m); e.ss = 6'(s);
    e.ring = r; e.sp = sp; e.se = se;
    exp_q.push_back(e);
  endtask

  task automatic snap(string n, int h, int m, int s, bit r);
    push(n, h, m, s, r, 1'b0, 1'b0);
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
  endtask

  task automatic edge_exp(string n, int h, int m, int s, bit r, bit ack);
    push(n, h, m, s, r, 1'b1, 1'b0);
    bus.tick_in = 1'b1;
    bus.alarm_ack = ack;
    step();
    bus.tick_in = 1'b0;
    bus.alarm_ack = 1'b0;
    step();
  endtask

  task automatic load(bit t, bit a, int h, int m);
    bus.set_time = t;
    bus.set_alarm = a;
    bus.set_hh = 5'(h);
    bus.set_mm = 6'(m);
    step();
    bus.set_time = 1'b0;
    bus.set_alarm = 1'b0;
  endtask

  // Loads 07:29 and walks up to the 07:30:00 match (alarm assumed at 07:30, ring idle).
  task automatic run_to_alarm(bit ack_on_match);
    load(1'b1, 1'b0, 7, 29);
    for (int s = 1; s < 60; s++) edge_exp("pre_match", 7, 29, s, 1'b0, 1'b0);
    edge_exp("match", 7, 30, 0, 1'b1, ack_on_match);
  endtask

  initial begin
    bus.tick_in = 1'b0; bus.set_time = 1'b0; bus.set_alarm = 1'b0;
    bus.set_hh = 5'd0; bus.set_mm = 6'd0; bus.alarm_en = 1'b0; bus.alarm_ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    snap("reset", 0, 0, 0, 1'b0);

    edge_exp("tick1", 0, 0, 1, 1'b0, 1'b0);
    edge_exp("tick2", 0, 0, 2, 1'b0, 1'b0);
    edge_exp("tick3", 0, 0, 3, 1'b0, 1'b0);
    push("hold_high", 0, 0, 4, 1'b0, 1'b1, 1'b0);
    bus.tick_in = 1'b1;
    repeat (10) step();
    bus.tick_in = 1'b0;
    step();
    snap("hold_end", 0, 0, 4, 1'b0);

    load(1'b1, 1'b0, 23, 59);
    snap("load_2359", 23, 59, 0, 1'b0);
    for (int s = 1; s < 60; s++) edge_exp("to_2359xx", 23, 59, s, 1'b0, 1'b0);
    edge_exp("midnight_wrap", 0, 0, 0, 1'b0, 1'b0);

    push("bad_time", 0, 0, 0, 1'b0, 1'b0, 1'b1);
    load(1'b1, 1'b0, 24, 10);
    push("bad_alarm", 0, 0, 0, 1'b0, 1'b0, 1'b1);
    load(1'b0, 1'b1, 7, 60);
    push("bad_both", 0, 0, 0, 1'b0, 1'b0, 1'b1);
    load(1'b1, 1'b1, 24, 10);
    step();
    push("bad_time_tick", 0, 0, 1, 1'b0, 1'b1, 1'b1);
    bus.tick_in = 1'b1;
    load(1'b1, 1'b0, 24, 0);
    bus.tick_in = 1'b0;
    step();
    snap("after_bad", 0, 0, 1, 1'b0);

    load(1'b0, 1'b1, 7, 30);
    bus.alarm_en = 1'b1;
    run_to_alarm(1'b0);
    for (int s = 1; s < 60; s++) edge_exp("ringing", 7, 30, s, 1'b1, 1'b0);
    edge_exp("ring_timeout", 7, 31, 0, 1'b0, 1'b0);

    run_to_alarm(1'b0);
    bus.alarm_ack = 1'b1;
    step();
    bus.alarm_ack = 1'b0;
    snap("ack_clears", 7, 30, 0, 1'b0);

    run_to_alarm(1'b1);
    edge_exp("ack_match_holds", 7, 30, 1, 1'b1, 1'b0);
    bus.alarm_en = 1'b0;
    step();
    bus.alarm_en = 1'b1;
    snap("disarm_clears", 7, 30, 1, 1'b0);

    load(1'b1, 1'b0, 7, 30);
    snap("load_no_match", 7, 30, 0, 1'b0);
    bus.tick_in = 1'b1;
    load(1'b1, 1'b0, 5, 5);
    bus.tick_in = 1'b0;
    snap("load_eats_tick", 5, 5, 0, 1'b0);

    run_to_alarm(1'b0);
    rst = 1'b1;
    bus.tick_in = 1'b1;
    snap("async_reset", 0, 0, 0, 1'b0);
    bus.tick_in = 1'b0;
    step();
    rst = 1'b0;
    step();
    snap("post_reset", 0, 0, 0, 1'b0);
    repeat (5) step();

    done_req = 1'b1;
    step();
    done_req = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
